// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bank bridge: framed cmd/addr byte, then
// auto-incrementing writes or reads. Ports: clk, rst_n, ss, done, dout,
// din, regs_flat, wr_stb, wr_addr, wr_data, busy.
module spi_reg_bridge #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  ID_BYTE  = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ss,
  input  logic                    done,
  input  logic [7:0]              dout,
  output logic [7:0]              din,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  output logic                    wr_stb,
  output logic [6:0]              wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy
);

  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NR = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ss_m;
  logic        r_ss_s;
  logic        r_armed;
  logic [6:0]  r_addr;
  logic [6:0]  w_addr_nxt;
  logic [7:0]  r_din;
  logic [7:0]  w_din_nxt;
  logic        w_we;
  logic [7:0]  r_regs [NUM_REGS];
  logic [7:0]  w_rd_cmd;
  logic [7:0]  w_rd_ptr;
  logic        w_cmd_in;
  logic        w_ptr_in;

  assign w_cmd_in = {1'b0, dout[6:0]} < NR;
  assign w_ptr_in = {1'b0, r_addr} < NR;
  assign w_rd_cmd = w_cmd_in ? r_regs[dout[AW-1:0]] : 8'h00;
  assign w_rd_ptr = w_ptr_in ? r_regs[r_addr[AW-1:0]] : 8'h00;

  // Sync flops reset low and r_armed blocks IDLE exit until ss has
  // really been seen high, so a frame left open across reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_m  <= 1'b0;
      r_ss_s  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_ss_m <= ss;
      r_ss_s <= r_ss_m;
      if (r_ss_s) r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_armed && !r_ss_s) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (done) begin
          w_addr_nxt = dout[6:0];
          if (dout[7]) begin
            w_state_nxt = S_READ;
            w_din_nxt   = w_rd_cmd;
            w_addr_nxt  = dout[6:0] + 7'd1;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (done) begin
          w_we       = w_ptr_in;
          w_addr_nxt = r_addr + 7'd1;
        end
      end
      S_READ: begin
        if (done) begin
          w_din_nxt  = w_rd_ptr;
          w_addr_nxt = r_addr + 7'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Byte on this edge is still processed; ss high then ends the frame.
    if (r_ss_s && r_state != S_IDLE) w_state_nxt = S_IDLE;
    if (w_state_nxt != S_READ) w_din_nxt = ID_BYTE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_din   <= ID_BYTE;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      wr_stb  <= w_we;
      if (w_we) begin
        r_regs[r_addr[AW-1:0]] <= dout;
        wr_addr <= r_addr;
        wr_data <= dout;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = r_regs[g];
  end

  assign din  = r_din;
  assign busy = (r_state != S_IDLE);

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level command decoder sitting directly downstream of the 8-bit SPI slave shifter. It consumes the shifter's `done`/`dout` byte stream and drives its `din` return byte. It implements a framed register protocol over an internal byte-wide register bank: the first byte of each frame is a command/address byte, and the following bytes are auto-incrementing writes or reads. Register contents are exported to the rest of the design, together with a per-write strobe.

## Interface
- `NUM_REGS`, 16: number of 8-bit registers implemented, at addresses 0..NUM_REGS-1; range 1..128.
- `ID_BYTE`, 8'hA5: byte returned on MISO whenever no read data is pending.
- `clk` input 1: single clock, the same clock as the SPI slave shifter.
- `rst_n` input 1: asynchronous active-low reset.
- `ss` input 1: raw SPI slave-select, active low; synchronized internally with two flops.
- `done` input 1: one-cycle pulse from the shifter; a byte has completed.
- `dout` input 8: received byte; valid while `done` is high.
- `din` output 8: next byte to transmit; sampled by the shifter while ss is high and on the edge where it raises `done`.
- `regs_flat` output 8*NUM_REGS: register bank; reg[i] occupies bits [8i+7:8i].
- `wr_stb` output 1: one-cycle pulse per accepted register write.
- `wr_addr` output 7: address of the last write.
- `wr_data` output 8: data of the last write.
- `busy` output 1: high while a frame is in progress (state != IDLE).

## Operation
- States: IDLE, CMD, WRITE, READ.
- IDLE: go to CMD when synchronized ss is low.
- CMD: on `done`, latch `addr_q = dout[6:0]`.
  - If `dout[7]=0`, go to WRITE.
  - If `dout[7]=1`, go to READ, load `din <= rd(addr)`, and set `addr_q <= addr_q+1`.
- WRITE: on each `done`:
  - If `addr_q < NUM_REGS`: reg[addr_q] <= dout; pulse wr_stb; wr_addr <= addr_q; wr_data <= dout.
  - Otherwise the write is silently dropped, with no wr_stb.
  - In both cases `addr_q <= addr_q+1`.
- READ: on each `done`, `din <= rd(addr_q)` and `addr_q <= addr_q+1`. Received MOSI bytes are ignored.
- rd(a) returns reg[a] when a < NUM_REGS, and 8'h00 otherwise.
- The address counter is 7 bits and wraps from 127 to 0. In-range wrap at NUM_REGS is not applied, so addresses past the bank read 0 and drop writes until the counter wraps.
- `din` returns to ID_BYTE in IDLE, in CMD, in WRITE, and on exit from any state.
- Synchronized ss high in any state: go to IDLE on the next edge and abort the frame. A partial byte produces no `done`, so there is no side effect.
- `done` and ss-high on the same cycle: the byte is processed first, and the state then goes to IDLE on that same edge.
- The register bank is writable only via SPI. No other write port exists.

## Timing
- Reset values: all regs 0, din = ID_BYTE, wr_stb 0, wr_addr 0, wr_data 0, busy 0, state IDLE, addr_q 0.
- Outputs are registered. wr_stb, wr_addr, wr_data and the regs_flat update on the edge after `done`, so they are valid 1 cycle after `done`.
- din updates 1 cycle after `done`, and the shifter samples it at the end of the following byte. Read latency is therefore one dummy byte:
  - frame byte 0 (command): MISO carries ID_BYTE;
  - byte 1: MISO carries ID_BYTE (dummy);
  - byte 2: MISO carries rd(A);
  - byte k: MISO carries rd(A+k-2).
- ss synchronizer latency is 2 cycles. busy rises 3 cycles after ss falls, and falls 3 cycles after ss rises.
- Back-to-back `done` pulses one cycle apart must each be processed. The FSM has no multi-cycle states.
- Asserting rst_n low mid-frame clears everything immediately and asynchronously. Bytes arriving after release are ignored until ss goes high and then low again: the FSM enters CMD only from IDLE, and IDLE is left only on an ss low level once ss has been seen high post-reset.

## Test plan
- Write burst: ss low, bytes 0x03, 0x11, 0x22, 0x33 -> reg3=0x11, reg4=0x22, reg5=0x33; three wr_stb pulses with wr_addr 3, 4, 5; busy high throughout the frame.
- Read burst after the write burst: bytes 0x83, 0x00, 0x00, 0x00, 0x00 -> MISO returns 0xA5, 0xA5, 0x11, 0x22, 0x33.
- Out of range: write 0x0F, 0xAA, 0xBB -> reg15=0xAA, 0xBB dropped, one wr_stb only. Read 0x8F, then 3 bytes -> MISO returns 0xA5, 0xA5, 0xAA, 0x00.
- Abort: raise ss after 4 bits of byte 1 in a write frame -> no register change, state IDLE. The next frame 0x01, 0x55 -> reg1=0x55.
- Async reset mid-read: pull rst_n low during byte 2 -> regs 0, din 0xA5, busy 0 in the same cycle. A new frame after ss toggles operates normally.
- Wrap: write command 0x7F, data 0x01, 0x02 -> 0x7F dropped (out of range), address wraps to 0, reg0=0x02.
